uart_tx_framer: RTL and testbench

Parametrised UART transmit framer. Accepts parallel words over a valid/ready handshake into a one-entry holding register and serialises them LSB-first. Each frame is start bit, DATA_WIDTH data bits, optional parity bit, then 1 or 2 stop bits. The parity bit is even or odd, and an error-injection mode inverts it. Sits between the APB register block (data/config) and the tx pad; bit timing comes from an external baud-rate tick.

---
 rtl/uart_tx_framer.sv | 99 +++++++++
 tb/tb_uart_tx_framer.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/uart_tx_framer.sv
// uart_tx_framer: one-entry holding register feeding an LSB-first UART frame serialiser with optional/injected parity
module uart_tx_framer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  bit_tick,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] parallel_data,
  input  logic                  parity_en,
  input  logic                  parity_odd,
  input  logic                  stop2,
  input  logic                  err_inj_en,
  output logic                  tx,
  output logic                  busy,
  output logic                  frame_done
);
  localparam int CW = $clog2(DATA_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATA_WIDTH - 1);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state;
  logic hold_valid, hold_par_en, hold_p, hold_stop2;
  logic [DATA_WIDTH-1:0] hold_data, shift;
  logic cur_par_en, cur_p, cur_stop2, stop_cnt;
  logic [CW-1:0] bit_cnt;
  logic stop_last, load;
  assign in_ready = ~hold_valid;
  always_comb begin
    stop_last = state == STOP && (!cur_stop2 || stop_cnt);
    load = bit_tick && hold_valid && (state == IDLE || stop_last);
  end
  // the frame's parity travels with the word, so later config changes cannot alter it
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      hold_valid <= 1'b0;
      hold_data <= '0;
      hold_par_en <= 1'b0;
      hold_p <= 1'b0;
      hold_stop2 <= 1'b0;
      shift <= '0;
      cur_par_en <= 1'b0;
      cur_p <= 1'b0;
      cur_stop2 <= 1'b0;
      stop_cnt <= 1'b0;
      bit_cnt <= '0;
      tx <= 1'b1;
      busy <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= bit_tick && stop_last;
      if (in_valid && !hold_valid) begin
        hold_valid <= 1'b1;
        hold_data <= parallel_data;
        hold_par_en <= parity_en;
        hold_p <= ^parallel_data ^ parity_odd ^ err_inj_en;
        hold_stop2 <= stop2;
      end
      if (load) begin
        hold_valid <= 1'b0;
        shift <= hold_data;
        cur_par_en <= hold_par_en;
        cur_p <= hold_p;
        cur_stop2 <= hold_stop2;
        state <= START;
        tx <= 1'b0;
        busy <= 1'b1;
      end else if (bit_tick) begin
        case (state)
          START: begin
            state <= DATA;
            bit_cnt <= '0;
            tx <= shift[0];
          end
          DATA: begin
            shift <= shift >> 1;
            bit_cnt <= bit_cnt + CW'(1);
            stop_cnt <= 1'b0;
            state <= bit_cnt != LAST ? DATA : cur_par_en ? PARITY : STOP;
            tx <= bit_cnt != LAST ? shift[1] : cur_par_en ? cur_p : 1'b1;
          end
          PARITY: begin
            state <= STOP;
            stop_cnt <= 1'b0;
            tx <= 1'b1;
          end
          STOP: begin
            stop_cnt <= 1'b1;
            state <= stop_last ? IDLE : STOP;
            busy <= !stop_last;
            tx <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_framer.sv
// tb_uart_tx_framer: random and directed frames checked against a bit-stream model built from the framing rules
module tb_uart_tx_framer;
  logic clk, reset, bit_tick, in_valid, in_ready, parity_en, parity_odd, stop2, err_inj_en;
  logic tx, busy, frame_done;
  logic [7:0] parallel_data;
  logic v5, r5, pe5, po5, s2_5, ei5, tx5, b5, fd5;
  logic [4:0] d5;
  int n_chk = 0, n_pass = 0, nbits = 0, tot = 0, tick_gap = 16;
  logic want[$];
  int ends[$];
  logic got5[$];
  logic busy_q = 1'b0;

  uart_tx_framer #(.DATA_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .bit_tick(bit_tick), .in_valid(in_valid), .in_ready(in_ready),
    .parallel_data(parallel_data), .parity_en(parity_en), .parity_odd(parity_odd), .stop2(stop2),
    .err_inj_en(err_inj_en), .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  uart_tx_framer #(.DATA_WIDTH(5)) dut5 (
    .clk(clk), .reset(reset), .bit_tick(bit_tick), .in_valid(v5), .in_ready(r5),
    .parallel_data(d5), .parity_en(pe5), .parity_odd(po5), .stop2(s2_5),
    .err_inj_en(ei5), .tx(tx5), .busy(b5), .frame_done(fd5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
    n_chk++;
    if (got === exp_v) n_pass++;
    else $display("FAIL %s got=%0h want=%0h", tag, got, exp_v);
  endtask

  task automatic push_frame(input logic [7:0] d, input logic pe, input logic po, input logic s2, input logic ei);
    want.push_back(1'b0);
    for (int i = 0; i < 8; i++) want.push_back(d[i]);
    if (pe) want.push_back(logic'(($countones(d) % 2 == 1) ^ po ^ ei));
    want.push_back(1'b1);
    if (s2) want.push_back(1'b1);
    tot += 10 + int'(pe) + int'(s2);
    ends.push_back(tot);
  endtask

  task automatic send(input logic [7:0] d, input logic pe, input logic po, input logic s2, input logic ei);
    int t = 0;
    while (!in_ready && t < 5000) begin @(posedge clk); #1; t++; end
    chk("ready_wait", 32'(t < 5000), 1);
    in_valid = 1'b1; parallel_data = d; parity_en = pe; parity_odd = po; stop2 = s2; err_inj_en = ei;
    @(posedge clk); #1;
    in_valid = 1'b0;
    push_frame(d, pe, po, s2, ei);
    chk("ready_low", in_ready, 0);
    parallel_data = 8'($urandom); parity_en = 1'($urandom); parity_odd = 1'($urandom);
    stop2 = 1'($urandom); err_inj_en = 1'($urandom);
  endtask

  task automatic wait_bits(input int n);
    int t = 0;
    while (nbits < n && t < 5000) begin @(posedge clk); #1; t++; end
    chk("bits_wait", 32'(t < 5000), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while ((want.size() != 0 || ends.size() != 0 || busy) && t < 5000) begin @(posedge clk); #1; t++; end
    chk("drain_wait", 32'(t < 5000), 1);
  endtask

  initial begin
    bit_tick = 1'b0;
    @(posedge clk); #1;
    forever begin
      int g;
      g = tick_gap != 0 ? tick_gap : int'($urandom_range(1, 5));
      bit_tick = 1'b1;
      @(posedge clk); #1;
      bit_tick = 1'b0;
      repeat (g - 1) begin @(posedge clk); #1; end
    end
  end

  // frame_done is checked before the same-edge bit so a back-to-back start bit is not counted early
  always @(negedge clk) if (reset) begin
    if (frame_done) chk("done_pos", nbits, ends.size() != 0 ? ends.pop_front() : -1);
    if (bit_tick && busy) begin
      nbits++;
      chk("bit_avail", 32'(want.size() != 0), 1);
      if (want.size() != 0) chk("tx_bit", tx, want.pop_front());
    end
    if (bit_tick && !busy) chk("idle_tx", tx, 1);
    if (busy && !busy_q) chk("ready_after_start", in_ready, 1);
    busy_q = busy;
    if (bit_tick && b5) got5.push_back(tx5);
  end

  initial begin
    int t;
    logic w5[$];
    reset = 1'b0; in_valid = 1'b0; parallel_data = '0; parity_en = 1'b0; parity_odd = 1'b0;
    stop2 = 1'b0; err_inj_en = 1'b0; v5 = 1'b0; d5 = '0; pe5 = 1'b1; po5 = 1'b0; s2_5 = 1'b0; ei5 = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_tx", tx, 1);
    chk("rst_ready", in_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    reset = 1'b1;
    send(8'hA5, 0, 0, 0, 0);
    wait_idle();
    chk("a5_bits", nbits, 10);
    send(8'h03, 1, 0, 0, 0);
    send(8'h03, 1, 1, 0, 0);
    send(8'h03, 1, 0, 0, 1);
    wait_idle();
    send(8'hFF, 0, 0, 1, 0);
    wait_idle();
    chk("ff_bits", nbits, 10 + 33 + 11);
    send(8'h11, 0, 0, 0, 0);
    wait_bits(nbits + 3);
    send(8'h22, 0, 0, 0, 0);
    t = 0;
    while (!frame_done && t < 5000) begin @(posedge clk); #1; t++; end
    chk("b2b_done_wait", 32'(t < 5000), 1);
    chk("b2b_busy", busy, 1);
    chk("b2b_tx_start", tx, 0);
    wait_idle();
    tick_gap = 4;
    send(8'h5A, 1, 0, 1, 0);
    wait_bits(nbits + 4);
    send(8'hC3, 0, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("abort_tx", tx, 1);
    chk("abort_busy", busy, 0);
    chk("abort_ready", in_ready, 1);
    want.delete(); ends.delete(); nbits = 0; tot = 0; busy_q = 1'b0;
    repeat (3) @(posedge clk); #1;
    reset = 1'b1;
    repeat (80) @(posedge clk); #1;
    chk("no_residual_bits", nbits, 0);
    chk("no_residual_busy", busy, 0);
    v5 = 1'b1; d5 = 5'h15; po5 = 1'b1;
    @(posedge clk); #1;
    v5 = 1'b0; po5 = 1'b0; d5 = 5'h0A;
    chk("dw5_ready_low", r5, 0);
    t = 0;
    while (!fd5 && t < 5000) begin @(posedge clk); #1; t++; end
    chk("dw5_done_wait", 32'(t < 5000), 1);
    w5.push_back(1'b0);
    for (int i = 0; i < 5; i++) w5.push_back(logic'((5'h15 >> i) & 5'h1));
    w5.push_back(logic'(($countones(5'h15) % 2 == 1) ^ 1'b1));
    w5.push_back(1'b1);
    chk("dw5_len", got5.size(), w5.size());
    for (int i = 0; i < w5.size() && i < got5.size(); i++) chk("dw5_bit", got5[i], w5[i]);
    tick_gap = 0;
    for (int k = 0; k < 40; k++) begin
      if ($urandom_range(0, 2) != 0) repeat ($urandom_range(1, 40)) begin @(posedge clk); #1; end
      send(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end
    wait_idle();
    chk("end_bits_left", want.size(), 0);
    chk("end_frames_left", ends.size(), 0);
    chk("end_ready", in_ready, 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
